// File: rtl/meter_pkg.sv
// Shared constants, mode encoding and request indices for the parking-meter count controller.
// Contents:
//   count width, saturation ceiling, low-time threshold, add amounts, preset values,
//   request bit positions in the pending mask, display mode enum, saturating add helper.
package meter_pkg;

  localparam int unsigned CountW = 14;

  localparam logic [CountW-1:0] MAX_COUNT  = 14'd9999;
  localparam logic [CountW-1:0] LOW_THRESH = 14'd200;

  localparam logic [CountW-1:0] ADD_10  = 14'd10;
  localparam logic [CountW-1:0] ADD_180 = 14'd180;
  localparam logic [CountW-1:0] ADD_200 = 14'd200;
  localparam logic [CountW-1:0] ADD_550 = 14'd550;

  localparam logic [CountW-1:0] PRESET_LO = 14'd10;
  localparam logic [CountW-1:0] PRESET_HI = 14'd205;

  // Bit positions in the pending mask; lower index = higher priority.
  localparam int unsigned NumReq  = 5;
  localparam int unsigned ReqDec  = 0;
  localparam int unsigned ReqA10  = 1;
  localparam int unsigned ReqA180 = 2;
  localparam int unsigned ReqA200 = 3;
  localparam int unsigned ReqA550 = 4;

  typedef enum logic [1:0] {
    ModeNormal = 2'd0,
    ModeLow    = 2'd1,
    ModeZero   = 2'd2
  } mode_e;

  // 15-bit sum so the carry out of 14 bits is never lost before clamping.
  function automatic logic [CountW-1:0] add_sat(input logic [CountW-1:0] a,
                                                input logic [CountW-1:0] k);
    logic [CountW:0] sum;
    sum = {1'b0, a} + {1'b0, k};
    return (sum > {1'b0, MAX_COUNT}) ? MAX_COUNT : sum[CountW-1:0];
  endfunction

endpackage

// File: rtl/meter_req_arb.sv
// Fixed-priority picker for the meter request mask.
// Ports:
//   req_i  request vector, bit 0 highest priority
//   gnt_o  one-hot grant of the highest-priority set bit, zero when no request
module meter_req_arb
  import meter_pkg::*;
(
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt_o = req_i & (~req_i + NumReq'(1));

endmodule

// File: rtl/meter_count_ctrl.sv
// Parking-meter count sequencer and display-mode controller.
// Serialises decrement/add requests onto one saturating 14-bit count, one per clock, and
// drives the blanking control for the seven-segment display.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   sec_tick, half_tick          1 Hz / 2 Hz one-cycle strobes
//   add10/add180/add200/add550   one-cycle add requests
//   set10, set205                level preset switches (set205 wins)
//   bcount                       current count 0..9999
//   disp_on                      1 = digits lit
//   mode                         0 NORMAL, 1 LOW, 2 ZERO
//   overrun                      pulse when a request merged into an already-pending bit
module meter_count_ctrl
  import meter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sec_tick,
  input  logic              half_tick,
  input  logic              add10,
  input  logic              add180,
  input  logic              add200,
  input  logic              add550,
  input  logic              set10,
  input  logic              set205,
  output logic [CountW-1:0] bcount,
  output logic              disp_on,
  output logic [1:0]        mode,
  output logic              overrun
);

  logic [CountW-1:0] bcount_q, bcount_d;
  logic [NumReq-1:0] pend_q, pend_d;
  logic              overrun_q, overrun_d;
  mode_e             mode_q, mode_d;
  logic              disp_on_q, disp_on_d;

  logic [NumReq-1:0] incoming, req, gnt;
  logic              preset;

  always_comb begin
    incoming          = '0;
    incoming[ReqDec]  = sec_tick;
    incoming[ReqA10]  = add10;
    incoming[ReqA180] = add180;
    incoming[ReqA200] = add200;
    incoming[ReqA550] = add550;
  end

  assign preset = set10 | set205;
  assign req    = pend_q | incoming;

  meter_req_arb u_arb (
    .req_i (req),
    .gnt_o (gnt)
  );

  // Count datapath
  always_comb begin
    pend_d    = req & ~gnt;
    overrun_d = |(pend_q & incoming);
    bcount_d  = bcount_q;
    if (preset) begin
      // Presets swallow everything, including would-be merges.
      pend_d    = '0;
      overrun_d = 1'b0;
      bcount_d  = set205 ? PRESET_HI : PRESET_LO;
    end else if (gnt[ReqDec]) begin
      bcount_d = (bcount_q == '0) ? '0 : bcount_q - 14'd1;
    end else if (gnt[ReqA10]) begin
      bcount_d = add_sat(bcount_q, ADD_10);
    end else if (gnt[ReqA180]) begin
      bcount_d = add_sat(bcount_q, ADD_180);
    end else if (gnt[ReqA200]) begin
      bcount_d = add_sat(bcount_q, ADD_200);
    end else if (gnt[ReqA550]) begin
      bcount_d = add_sat(bcount_q, ADD_550);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bcount_q  <= '0;
      pend_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      bcount_q  <= bcount_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  // Display FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q    <= ModeZero;
      disp_on_q <= 1'b1;
    end else begin
      mode_q    <= mode_d;
      disp_on_q <= disp_on_d;
    end
  end

  // Display FSM: next state, decided from the registered count
  always_comb begin
    mode_d    = ModeNormal;
    disp_on_d = disp_on_q;
    if (bcount_q == '0) begin
      mode_d = ModeZero;
    end else if (bcount_q < LOW_THRESH) begin
      mode_d = ModeLow;
    end

    if (mode_d != mode_q) begin
      disp_on_d = 1'b1;
    end else begin
      unique case (mode_q)
        ModeLow:  if (sec_tick)  disp_on_d = ~disp_on_q;
        ModeZero: if (half_tick) disp_on_d = ~disp_on_q;
        default:  disp_on_d = 1'b1;
      endcase
    end
  end

  // Display FSM: outputs
  always_comb begin
    mode    = mode_q;
    disp_on = disp_on_q;
  end

  assign bcount  = bcount_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_meter_count_ctrl.sv
module tb_meter_count_ctrl;

  logic        clk;
  logic        reset_n;
  logic        sec_tick, half_tick;
  logic        add10, add180, add200, add550;
  logic        set10, set205;
  logic [13:0] bcount;
  logic        disp_on;
  logic [1:0]  mode;
  logic        overrun;

  meter_count_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sec_tick  (sec_tick),
    .half_tick (half_tick),
    .add10     (add10),
    .add180    (add180),
    .add200    (add200),
    .add550    (add550),
    .set10     (set10),
    .set205    (set205),
    .bcount    (bcount),
    .disp_on   (disp_on),
    .mode      (mode),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int md;
    bit disp;
    bit ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: requests in priority order DEC, +10, +180, +200, +550.
  int m_cnt;
  bit m_pend[5];
  int m_md;
  bit m_disp;
  bit m_ov;
  int amount[5] = '{-1, 10, 180, 200, 550};

  function automatic int mode_of(int c);
    if (c == 0) return 2;
    if (c < 200) return 1;
    return 0;
  endfunction

  task automatic model_step(input bit rst_n, input bit inc[5], input bit sec, input bit half,
                            input bit s10, input bit s205);
    int nm;
    if (!rst_n) begin
      m_cnt = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
      m_md = 2; m_disp = 1; m_ov = 0;
      return;
    end
    nm = mode_of(m_cnt);
    if (nm != m_md)                m_disp = 1;
    else if (m_md == 0)            m_disp = 1;
    else if (m_md == 1 && sec)     m_disp = !m_disp;
    else if (m_md == 2 && half)    m_disp = !m_disp;
    m_md = nm;
    m_ov = 0;
    if (s10 || s205) begin
      m_cnt = s205 ? 205 : 10;
      foreach (m_pend[i]) m_pend[i] = 0;
      return;
    end
    for (int i = 0; i < 5; i++) begin
      if (inc[i]) begin
        if (m_pend[i]) m_ov = 1;
        m_pend[i] = 1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (m_pend[i]) begin
        m_pend[i] = 0;
        m_cnt = m_cnt + amount[i];
        if (m_cnt < 0) m_cnt = 0;
        if (m_cnt > 9999) m_cnt = 9999;
        break;
      end
    end
  endtask

  // Drive one cycle of stimulus (called at a falling edge), predict, advance.
  // adds = {550, 200, 180, 10}; sets = {205, 10}
  task automatic cyc(input bit rst_n, input bit [3:0] adds, input bit sec, input bit half,
                     input bit [1:0] sets);
    bit   inc[5];
    exp_t e;
    half      = half | sec;
    reset_n   = rst_n;
    sec_tick  = sec;
    half_tick = half;
    add10     = adds[0];
    add180    = adds[1];
    add200    = adds[2];
    add550    = adds[3];
    set10     = sets[0];
    set205    = sets[1];
    inc[0] = sec; inc[1] = adds[0]; inc[2] = adds[1]; inc[3] = adds[2]; inc[4] = adds[3];
    model_step(rst_n, inc, sec, half, sets[0], sets[1]);
    e.cnt = m_cnt; e.md = m_md; e.disp = m_disp; e.ov = m_ov;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
  endtask

  // Monitor: outputs are presented every cycle; compare just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bcount", int'(bcount), e.cnt);
        check("mode", int'(mode), e.md);
        check("disp_on", int'(disp_on), int'(e.disp));
        check("overrun", int'(overrun), int'(e.ov));
      end
    end
  end

  initial begin
    int  preset_hold;
    bit  [1:0] preset_sel;
    bit  [3:0] adds;
    bit  sec, half, rst_n;

    // Reset, then ZERO mode blinking on half ticks
    cyc(0, 4'b0000, 0, 0, 2'b00);
    cyc(0, 4'b0000, 0, 0, 2'b00);
    for (int i = 0; i < 6; i++) cyc(1, 4'b0000, (i == 3), (i % 2 == 1), 2'b00);
    // add180 -> 180, LOW one cycle later
    cyc(1, 4'b0010, 0, 0, 2'b00);
    cyc(1, 4'b0000, 0, 0, 2'b00);
    cyc(1, 4'b0000, 0, 0, 2'b00);
    // add10 + add200 + sec together: 179, 189, 389
    cyc(1, 4'b0101, 1, 1, 2'b00);
    for (int i = 0; i < 4; i++) cyc(1, 4'b0000, 0, 0, 2'b00);

    // Climb to 9800 from 0, then saturate
    cyc(0, 4'b0000, 0, 0, 2'b00);
    for (int i = 0; i < 17; i++) cyc(1, 4'b1000, 0, 0, 2'b00);
    for (int i = 0; i < 2; i++)  cyc(1, 4'b0100, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++)  cyc(1, 4'b0001, 0, 0, 2'b00);
    cyc(1, 4'b1000, 0, 0, 2'b00);
    cyc(1, 4'b0100, 0, 0, 2'b00);
    cyc(1, 4'b0000, 0, 0, 2'b00);

    // Backlog with merged add10
    cyc(1, 4'b0111, 1, 1, 2'b00);
    cyc(1, 4'b0001, 0, 0, 2'b00);
    cyc(1, 4'b0001, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) cyc(1, 4'b0000, 0, 0, 2'b00);

    // Hold set205 while requests arrive; all discarded
    for (int i = 0; i < 5; i++) cyc(1, 4'b1000, (i % 2 == 0), 0, 2'b10);
    for (int i = 0; i < 4; i++) cyc(1, 4'b0000, 0, 0, 2'b00);

    // Count down to 0 and stay there
    cyc(1, 4'b0000, 0, 0, 2'b01);
    for (int i = 0; i < 14; i++) cyc(1, 4'b0000, 1, 1, 2'b00);
    cyc(1, 4'b0000, 0, 0, 2'b00);

    // Reset in the middle of a backlog
    cyc(1, 4'b1111, 1, 1, 2'b00);
    cyc(0, 4'b0000, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) cyc(1, 4'b0000, 0, 0, 2'b00);

    // Randomised traffic
    preset_hold = 0;
    preset_sel  = 2'b00;
    for (int i = 0; i < 2000; i++) begin
      adds = 4'b0000;
      for (int b = 0; b < 4; b++) adds[b] = ($urandom_range(0, 5) == 0);
      sec   = ($urandom_range(0, 7) == 0);
      half  = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      if (preset_hold == 0 && $urandom_range(0, 59) == 0) begin
        preset_hold = $urandom_range(1, 4);
        preset_sel  = 2'($urandom_range(1, 3));
      end
      if (preset_hold > 0) begin
        preset_hold--;
        cyc(rst_n, adds, sec, half, preset_sel);
      end else begin
        cyc(rst_n, adds, sec, half, 2'b00);
      end
    end

    cyc(1, 4'b0000, 0, 0, 2'b00);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
